elevator_car_controller: RTL and testbench

Drives the two elevator cars of the simulation. It is the responder to the people controller: it accumulates the 12-bit `floorsRequested` and `floorDestinations` demand, moves each car in half-floor steps at a rate set by `simSpeed`, and opens doors at serviced floors. It publishes each car's position on `elevatorStates`, which the people controller and the renderer consume.

---
 rtl/elevator_car_controller.sv | 165 ++++++++++++++++
 tb/tb_elevator_car_controller.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_car_controller.sv
// Two independent elevator cars moving in half-floor steps on a shared prescaler tick.
// Each car latches its own 6-floor stop set and opens its doors at serviced floors.
module elevator_car_controller #(
    parameter logic [19:0] STEP_COUNT = 20'd500000,
    parameter int          DOOR_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  simState,
    input  logic [2:0]  simSpeed,
    input  logic [11:0] floorsRequested,
    input  logic [11:0] floorDestinations,
    output logic [7:0]  elevatorStates,
    output logic [1:0]  doorsOpen,
    output logic [11:0] pendingFloors
);

    typedef enum logic [1:0] {IDLE, UP, DOWN, DOORS} car_state_t;

    typedef struct packed {
        car_state_t  state;
        logic [3:0]  pos;
        logic        dir_up;
        logic [7:0]  door_cnt;
    } car_t;

    localparam logic [1:0] SIM_START  = 2'd0;
    localparam logic [1:0] SIM_RUN    = 2'd1;
    localparam logic [1:0] SIM_ENDING = 2'd3;
    localparam logic [7:0] DOOR_LOAD  = 8'(DOOR_TICKS - 1);
    localparam car_t CAR_RESET = '{state: IDLE, pos: 4'd0, dir_up: 1'b1, door_cnt: 8'd0};

    car_t        car_q [2];
    car_t        car_d [2];
    logic [19:0] presc_q;
    logic [20:0] presc_sum;
    logic        tick;
    logic        clear;
    logic        run;
    logic [11:0] pend_q;
    logic [11:0] pend_d;

    assign clear     = (simState == SIM_START) || (simState == SIM_ENDING);
    assign run       = (simState == SIM_RUN);
    assign presc_sum = {1'b0, presc_q} + {18'b0, simSpeed};
    assign tick      = run && (presc_sum >= {1'b0, STEP_COUNT});

    // Bit i set when floor i lies strictly above (or below) the given floor.
    function automatic logic [7:0] floor_mask(input logic [2:0] floor, input logic want_above);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i] = want_above ? (i > int'(floor)) : (i < int'(floor));
        end
        return m;
    endfunction

    logic [7:0] car_pend;
    logic [2:0] floor;
    logic [3:0] next_pos;
    logic       at_floor;
    logic       above;
    logic       below;

    always_comb begin
        pend_d   = pend_q | floorsRequested | floorDestinations;
        car_pend = '0;
        floor    = '0;
        next_pos = '0;
        at_floor = 1'b0;
        above    = 1'b0;
        below    = 1'b0;
        for (int c = 0; c < 2; c++) begin
            car_d[c] = car_q[c];
            car_pend = {2'b00, pend_q[c*6 +: 6]};
            floor    = car_q[c].pos[3:1];
            next_pos = car_q[c].pos;
            at_floor = car_pend[floor];
            above    = |(car_pend & floor_mask(floor, 1'b1));
            below    = |(car_pend & floor_mask(floor, 1'b0));
            // Open doors swallow any request for their own floor.
            if (car_q[c].state == DOORS) begin
                pend_d[c*6 + int'(floor)] = 1'b0;
            end
            if (tick) begin
                case (car_q[c].state)
                    IDLE: begin
                        if (at_floor) begin
                            car_d[c].state    = DOORS;
                            car_d[c].door_cnt = DOOR_LOAD;
                        end else if (above) begin
                            car_d[c].state  = UP;
                            car_d[c].dir_up = 1'b1;
                        end else if (below) begin
                            car_d[c].state  = DOWN;
                            car_d[c].dir_up = 1'b0;
                        end
                    end
                    UP: begin
                        next_pos     = (car_q[c].pos == 4'd10) ? car_q[c].pos : car_q[c].pos + 4'd1;
                        car_d[c].pos = next_pos;
                        if (!next_pos[0] && car_pend[next_pos[3:1]]) begin
                            car_d[c].state    = DOORS;
                            car_d[c].door_cnt = DOOR_LOAD;
                        end else if (next_pos == 4'd10) begin
                            car_d[c].state = IDLE;
                        end
                    end
                    DOWN: begin
                        next_pos     = (car_q[c].pos == 4'd0) ? car_q[c].pos : car_q[c].pos - 4'd1;
                        car_d[c].pos = next_pos;
                        if (!next_pos[0] && car_pend[next_pos[3:1]]) begin
                            car_d[c].state    = DOORS;
                            car_d[c].door_cnt = DOOR_LOAD;
                        end else if (next_pos == 4'd0) begin
                            car_d[c].state = IDLE;
                        end
                    end
                    DOORS: begin
                        if (car_q[c].door_cnt != 8'd0) begin
                            car_d[c].door_cnt = car_q[c].door_cnt - 8'd1;
                        end else if (car_q[c].dir_up && above) begin
                            car_d[c].state = UP;
                        end else if (below) begin
                            car_d[c].state  = DOWN;
                            car_d[c].dir_up = 1'b0;
                        end else if (above) begin
                            car_d[c].state  = UP;
                            car_d[c].dir_up = 1'b1;
                        end else begin
                            car_d[c].state = IDLE;
                        end
                    end
                    default: car_d[c] = CAR_RESET;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q  <= '0;
            pend_q   <= '0;
            car_q[0] <= CAR_RESET;
            car_q[1] <= CAR_RESET;
        end else if (clear) begin
            presc_q  <= '0;
            pend_q   <= '0;
            car_q[0] <= CAR_RESET;
            car_q[1] <= CAR_RESET;
        end else begin
            // PAUSE holds the prescaler; car_d equals car_q whenever there is no tick.
            pend_q   <= pend_d;
            car_q[0] <= car_d[0];
            car_q[1] <= car_d[1];
            if (run) begin
                presc_q <= tick ? 20'd0 : presc_sum[19:0];
            end
        end
    end

    assign elevatorStates = {car_q[1].pos, car_q[0].pos};
    assign doorsOpen      = {car_q[1].state == DOORS, car_q[0].state == DOORS};
    assign pendingFloors  = pend_q;

endmodule

// File: tb/tb_elevator_car_controller.sv
// Bench for elevator_car_controller: a per-cycle reference model fills an expected queue
// that a negedge monitor drains, plus directed checks of the key travel scenarios.
module tb_elevator_car_controller;

    localparam int STEP = 4;
    localparam int DT   = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  simState;
    logic [2:0]  simSpeed;
    logic [11:0] floorsRequested;
    logic [11:0] floorDestinations;
    logic [7:0]  elevatorStates;
    logic [1:0]  doorsOpen;
    logic [11:0] pendingFloors;

    elevator_car_controller #(.STEP_COUNT(20'(STEP)), .DOOR_TICKS(DT)) dut (
        .clk               (clk),
        .rst               (rst),
        .simState          (simState),
        .simSpeed          (simSpeed),
        .floorsRequested   (floorsRequested),
        .floorDestinations (floorDestinations),
        .elevatorStates    (elevatorStates),
        .doorsOpen         (doorsOpen),
        .pendingFloors     (pendingFloors)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [21:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 rising, 2 falling, 3 doors open
    int m_presc;
    int m_pos[2];
    int m_mode[2];
    bit m_dirup[2];
    int m_door[2];
    bit m_pend[12];

    function automatic bit m_at(int c, int f);
        return m_pend[c*6 + f];
    endfunction

    function automatic bit m_above(int c, int f);
        for (int g = f + 1; g < 6; g++) if (m_pend[c*6 + g]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_below(int c, int f);
        for (int g = 0; g < f; g++) if (m_pend[c*6 + g]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_clear();
        m_presc = 0;
        for (int c = 0; c < 2; c++) begin
            m_pos[c] = 0; m_mode[c] = 0; m_dirup[c] = 1'b1; m_door[c] = 0;
        end
        for (int k = 0; k < 12; k++) m_pend[k] = 1'b0;
    endtask

    task automatic m_open(int c);
        m_mode[c] = 3;
        m_door[c] = DT - 1;
    endtask

    task automatic m_car_tick(int c);
        int f = m_pos[c] / 2;
        case (m_mode[c])
            0: begin
                if (m_at(c, f)) m_open(c);
                else if (m_above(c, f)) begin m_mode[c] = 1; m_dirup[c] = 1'b1; end
                else if (m_below(c, f)) begin m_mode[c] = 2; m_dirup[c] = 1'b0; end
            end
            1: begin
                if (m_pos[c] < 10) m_pos[c]++;
                if (m_pos[c] % 2 == 0 && m_at(c, m_pos[c] / 2)) m_open(c);
                else if (m_pos[c] == 10) m_mode[c] = 0;
            end
            2: begin
                if (m_pos[c] > 0) m_pos[c]--;
                if (m_pos[c] % 2 == 0 && m_at(c, m_pos[c] / 2)) m_open(c);
                else if (m_pos[c] == 0) m_mode[c] = 0;
            end
            default: begin
                if (m_door[c] > 0) m_door[c]--;
                else if (m_dirup[c] && m_above(c, f)) m_mode[c] = 1;
                else if (m_below(c, f)) begin m_mode[c] = 2; m_dirup[c] = 1'b0; end
                else if (m_above(c, f)) begin m_mode[c] = 1; m_dirup[c] = 1'b1; end
                else m_mode[c] = 0;
            end
        endcase
    endtask

    task automatic model_step(input bit r, input logic [1:0] ss, input logic [2:0] sp,
                              input logic [11:0] fr, input logic [11:0] fd);
        bit nxt[12];
        bit tk;
        if (r || ss == 2'd0 || ss == 2'd3) begin
            m_clear();
        end else begin
            for (int k = 0; k < 12; k++) nxt[k] = m_pend[k] | fr[k] | fd[k];
            for (int c = 0; c < 2; c++) if (m_mode[c] == 3) nxt[c*6 + m_pos[c] / 2] = 1'b0;
            tk = 1'b0;
            if (ss == 2'd1) begin
                m_presc += int'(sp);
                if (m_presc >= STEP) begin tk = 1'b1; m_presc = 0; end
            end
            if (tk) for (int c = 0; c < 2; c++) m_car_tick(c);
            m_pend = nxt;
        end
    endtask

    function automatic logic [21:0] m_pack();
        logic [21:0] v;
        v[3:0] = 4'(m_pos[0]);
        v[7:4] = 4'(m_pos[1]);
        v[8]   = (m_mode[0] == 3);
        v[9]   = (m_mode[1] == 3);
        for (int k = 0; k < 12; k++) v[10 + k] = m_pend[k];
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bit r, input logic [1:0] ss, input logic [2:0] sp,
                         input logic [11:0] fr, input logic [11:0] fd);
        @(negedge clk);
        #1;
        rst = r; simState = ss; simSpeed = sp;
        floorsRequested = fr; floorDestinations = fd;
        model_step(r, ss, sp, fr, fd);
        exp_q.push_back(m_pack());
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        check("pre_rst_left_pos", int'(elevatorStates[3:0]), 7);
        rst = 1'b1;
        #1;
        check("async_rst_states", int'(elevatorStates), 0);
        check("async_rst_doors", int'(doorsOpen), 0);
        check("async_rst_pending", int'(pendingFloors), 0);
        model_step(1'b1, simState, simSpeed, 12'd0, 12'd0);
        exp_q.push_back(m_pack());
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [21:0] mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("mon_states", int'(elevatorStates), int'(mon_e[7:0]));
            check("mon_doors", int'(doorsOpen), int'(mon_e[9:8]));
            check("mon_pending", int'(pendingFloors), int'(mon_e[21:10]));
        end
    end

    // ---------------- stimulus ----------------
    int door_cycles;
    int seq[$];
    int exp_seq[13];
    int last;
    bit left_door_seen, left_moved, right_door0_seen;
    logic [1:0]  rs;
    logic [2:0]  rsp;
    logic [11:0] rfr, rfd;

    initial begin
        rst = 1'b0; simState = 2'd0; simSpeed = 3'd0;
        floorsRequested = '0; floorDestinations = '0;
        m_clear();
        #1 rst = 1'b1;
        #1;
        check("reset_states", int'(elevatorStates), 0);
        check("reset_doors", int'(doorsOpen), 0);
        check("reset_pending", int'(pendingFloors), 0);
        drive(1, 2'd0, 3'd0, 12'd0, 12'd0);
        drive(0, 2'd0, 3'd0, 12'd0, 12'd0);

        // single hall call for left floor 3
        drive(0, 2'd1, 3'd1, 12'h008, 12'd0);
        settle();
        check("s1_pending_next", int'(pendingFloors), 'h008);
        door_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            drive(0, 2'd1, 3'd1, 12'd0, 12'd0);
            if (doorsOpen[0]) door_cycles++;
        end
        settle();
        check("s1_door_cycles", door_cycles, DT * STEP);
        check("s1_final_states", int'(elevatorStates), 'h06);
        check("s1_final_doors", int'(doorsOpen), 0);
        check("s1_final_pending", int'(pendingFloors), 0);

        // floors 1 and 5 while parked at floor 3 heading up
        exp_seq = '{6, 7, 8, 9, 10, 9, 8, 7, 6, 5, 4, 3, 2};
        seq.delete();
        seq.push_back(6);
        last = 6;
        drive(0, 2'd1, 3'd1, 12'h022, 12'd0);
        for (int i = 0; i < 150; i++) begin
            drive(0, 2'd1, 3'd1, 12'd0, 12'd0);
            if (int'(elevatorStates[3:0]) != last) begin
                last = int'(elevatorStates[3:0]);
                seq.push_back(last);
            end
        end
        check("s2_seq_len", seq.size(), 13);
        for (int i = 0; i < 13; i++) begin
            if (i < seq.size()) check($sformatf("s2_seq_%0d", i), seq[i], exp_seq[i]);
        end

        // right car: hall call at floor 0 plus destination floor 5
        drive(0, 2'd0, 3'd0, 12'd0, 12'd0);
        drive(0, 2'd1, 3'd1, 12'h040, 12'h800);
        left_door_seen = 0; left_moved = 0; right_door0_seen = 0;
        for (int i = 0; i < 150; i++) begin
            drive(0, 2'd1, 3'd1, 12'd0, 12'd0);
            if (doorsOpen[0]) left_door_seen = 1;
            if (elevatorStates[3:0] != 4'd0) left_moved = 1;
            if (doorsOpen[1] && elevatorStates[7:4] == 4'd0) right_door0_seen = 1;
        end
        settle();
        check("s3_left_doors", int'(left_door_seen), 0);
        check("s3_left_moved", int'(left_moved), 0);
        check("s3_right_door_at0", int'(right_door0_seen), 1);
        check("s3_final_states", int'(elevatorStates), 'hA0);

        // zero speed freezes motion
        drive(0, 2'd1, 3'd0, 12'd0, 12'h040);
        for (int i = 0; i < 999; i++) drive(0, 2'd1, 3'd0, 12'd0, 12'd0);
        settle();
        check("spd0_states", int'(elevatorStates), 'hA0);
        check("spd0_pending", int'(pendingFloors), 'h040);
        check("spd0_doors", int'(doorsOpen), 0);

        // pause mid-travel at right pos 5
        drive(0, 2'd0, 3'd0, 12'd0, 12'd0);
        drive(0, 2'd1, 3'd1, 12'h800, 12'd0);
        for (int i = 0; i < 200 && m_pos[1] != 5; i++) drive(0, 2'd1, 3'd1, 12'd0, 12'd0);
        for (int i = 0; i < 100; i++) drive(0, 2'd2, 3'd1, (i == 50) ? 12'h004 : 12'd0, 12'd0);
        settle();
        check("pause_right_pos", int'(elevatorStates[7:4]), 5);
        check("pause_req_latched", int'(pendingFloors[2]), 1);
        check("pause_target_kept", int'(pendingFloors[11]), 1);
        for (int i = 0; i < 20 && m_pos[1] == 5; i++) drive(0, 2'd1, 3'd1, 12'd0, 12'd0);
        settle();
        check("resume_right_pos", int'(elevatorStates[7:4]), 6);

        // randomized segments
        for (int s = 0; s < 25; s++) begin
            case ($urandom_range(0, 9))
                0:       rs = 2'd0;
                1:       rs = 2'd3;
                2, 3:    rs = 2'd2;
                default: rs = 2'd1;
            endcase
            rsp = 3'($urandom_range(0, 7));
            for (int i = 0; i < int'($urandom_range(5, 30)); i++) begin
                rfr = ($urandom_range(0, 7) == 0) ? (12'd1 << $urandom_range(0, 11)) : 12'd0;
                rfd = ($urandom_range(0, 7) == 0) ? (12'd1 << $urandom_range(0, 11)) : 12'd0;
                drive(0, rs, rsp, rfr, rfd);
            end
        end

        // ENDING clears on the next clock
        drive(0, 2'd1, 3'd5, 12'h841, 12'd0);
        drive(0, 2'd3, 3'd5, 12'h0FF, 12'd0);
        settle();
        check("ending_states", int'(elevatorStates), 0);
        check("ending_doors", int'(doorsOpen), 0);
        check("ending_pending", int'(pendingFloors), 0);

        // asynchronous reset while the left car is at pos 7
        drive(0, 2'd0, 3'd0, 12'd0, 12'd0);
        drive(0, 2'd1, 3'd1, 12'h020, 12'd0);
        for (int i = 0; i < 200 && m_pos[0] != 7; i++) drive(0, 2'd1, 3'd1, 12'd0, 12'd0);
        async_reset();
        drive(0, 2'd1, 3'd3, 12'h004, 12'h200);
        for (int i = 0; i < 40; i++) drive(0, 2'd1, 3'd3, 12'd0, 12'd0);

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
